// File: rtl/multi_chan_counter_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ctrl_signal_types (package)                           |
// | Brief    : Shared control-signal types for the page-access-      |
// |            counter datapath: controller states, updater mode,    |
// |            counter-buffer port owner and arbiter owner.          |
// | Revision : 1.1 - DRAIN_S added for multi-channel quiescing       |
// +------------------------------------------------------------------+
package ctrl_signal_types;

    typedef enum logic [2:0] {
        IDLE_S       = 3'd0,
        COUNTING_S   = 3'd1,
        DRAIN_S      = 3'd2,
        WRITE_BACK_S = 3'd3,
        ZERO_OUT_S   = 3'd4
    } ctrl_state_t;

    typedef enum logic [0:0] {
        ZERO_OUT_COUNTER   = 1'b0,
        WRITE_BACK_COUNTER = 1'b1
    } updater_mode_t;

    typedef enum logic [1:0] {
        USER_B    = 2'd0,
        CAFU_B    = 2'd1,
        UPDATER_B = 2'd2
    } buf_port_sel_t;

    typedef enum logic [0:0] {
        USER_A    = 1'b0,
        UPDATER_A = 1'b1
    } arbiter_sel_t;

endpackage
`default_nettype wire

// File: rtl/multi_chan_counter_ctrl_outstanding_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : outstanding_cnt                                       |
// | Brief    : Saturating up/down counter of in-flight requests on   |
// |            one channel, with a zero flag.                        |
// | Revision : 1.0 - initial                                         |
// +------------------------------------------------------------------+
module outstanding_cnt #(
    parameter int WIDTH = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_zero
);

    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    // Count up on request, down on response; hold at the rails and when both fire
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/multi_chan_counter_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : multi_chan_counter_ctrl                               |
// | Brief    : Control FSM for the page-access-counter datapath.     |
// |            Quiesces all channels, then runs write-back and/or    |
// |            zero-out, latching CSR commands that arrive busy.     |
// | Revision : 1.0 - initial multi-channel version                   |
// +------------------------------------------------------------------+
module multi_chan_counter_ctrl
    import ctrl_signal_types::*;
#(
    parameter int NUM_CH        = 2,
    parameter int OUTST_W       = 6,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_CH-1:0]   emif_amm_ready,
    input  logic [NUM_CH-1:0]   mc_req_fire,
    input  logic [NUM_CH-1:0]   mc_rsp_fire,
    output logic [NUM_CH-1:0]   eac2mc_ready,
    input  logic                csr_write_back,
    input  logic                csr_zero_out,
    input  logic                csr_clear_err,
    output logic                mem_updater_start,
    output updater_mode_t       mem_updater_mode,
    input  logic                mem_updater_done,
    output logic                cafu_start,
    input  logic                cafu_done,
    output buf_port_sel_t       buf_port_sel,
    output arbiter_sel_t        arbiter_sel,
    output logic                is_writing_back,
    output logic                busy,
    output logic                op_done,
    output logic                drain_timeout_err
);

    localparam int              c_TO_W    = $clog2(DRAIN_TIMEOUT);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(DRAIN_TIMEOUT - 1);

    ctrl_state_t        r_state;
    ctrl_state_t        w_next_state;
    logic               r_pend_wb;
    logic               r_pend_zo;
    logic [c_TO_W-1:0]  r_drain_cnt;
    logic               r_err;
    logic               r_cafu_start;
    logic               r_upd_start;
    logic               r_op_done;
    logic [NUM_CH-1:0]  w_zero;
    logic               w_all_zero;
    logic               w_timeout;
    logic               w_enter_wb;
    logic               w_enter_zo;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        outstanding_cnt #(
            .WIDTH (OUTST_W)
        ) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .i_inc   (mc_req_fire[g]),
            .i_dec   (mc_rsp_fire[g]),
            .o_zero  (w_zero[g])
        );
    end

    assign w_all_zero = &w_zero;
    assign w_timeout  = (r_state == DRAIN_S) && (r_drain_cnt == c_TO_LAST);
    assign w_enter_wb = (w_next_state == WRITE_BACK_S) && (r_state != WRITE_BACK_S);
    assign w_enter_zo = (w_next_state == ZERO_OUT_S) && (r_state != ZERO_OUT_S);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE_S;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next_state     = r_state;
        eac2mc_ready     = '0;
        buf_port_sel     = USER_B;
        arbiter_sel      = USER_A;
        mem_updater_mode = ZERO_OUT_COUNTER;
        is_writing_back  = 1'b0;
        busy             = 1'b1;
        case (r_state)
            IDLE_S: begin
                w_next_state = COUNTING_S;
            end
            COUNTING_S: begin
                // Only state where traffic flows; the pulse itself closes it next cycle
                eac2mc_ready = emif_amm_ready;
                busy         = 1'b0;
                if (r_pend_wb || r_pend_zo || csr_write_back || csr_zero_out) begin
                    w_next_state = DRAIN_S;
                end
            end
            DRAIN_S: begin
                if (w_all_zero || w_timeout) begin
                    w_next_state = r_pend_wb ? WRITE_BACK_S : ZERO_OUT_S;
                end
            end
            WRITE_BACK_S: begin
                buf_port_sel     = CAFU_B;
                mem_updater_mode = WRITE_BACK_COUNTER;
                is_writing_back  = 1'b1;
                if (cafu_done) begin
                    w_next_state = r_pend_zo ? ZERO_OUT_S : COUNTING_S;
                end
            end
            ZERO_OUT_S: begin
                buf_port_sel = UPDATER_B;
                if (mem_updater_done) begin
                    w_next_state = COUNTING_S;
                end
            end
            default: begin
                w_next_state = IDLE_S;
            end
        endcase
    end

    // Pending commands, drain timer, sticky error and registered pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pend_wb    <= 1'b0;
            r_pend_zo    <= 1'b0;
            r_drain_cnt  <= '0;
            r_err        <= 1'b0;
            r_cafu_start <= 1'b0;
            r_upd_start  <= 1'b0;
            r_op_done    <= 1'b0;
        end else begin
            // A pulse coinciding with entry is kept so it is serviced again later
            r_pend_wb    <= (r_pend_wb && !w_enter_wb) || csr_write_back;
            r_pend_zo    <= (r_pend_zo && !w_enter_zo) || csr_zero_out;
            r_drain_cnt  <= (r_state == DRAIN_S) ? r_drain_cnt + 1'b1 : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (csr_clear_err) begin
                r_err <= 1'b0;
            end
            r_cafu_start <= w_enter_wb;
            r_upd_start  <= w_enter_zo;
            r_op_done    <= (w_next_state == COUNTING_S) &&
                            ((r_state == WRITE_BACK_S) || (r_state == ZERO_OUT_S));
        end
    end

    assign cafu_start        = r_cafu_start;
    assign mem_updater_start = r_upd_start;
    assign op_done           = r_op_done;
    assign drain_timeout_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_multi_chan_counter_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_multi_chan_counter_ctrl                            |
// | Brief    : Directed self-checking bench for the counter control  |
// |            FSM: saturation, write-back, chained, timeout, reset. |
// | Revision : 1.0 - initial                                         |
// +------------------------------------------------------------------+
module tb_multi_chan_counter_ctrl;
    import ctrl_signal_types::*;

    localparam int NUM_CH        = 2;
    localparam int OUTST_W       = 2;
    localparam int DRAIN_TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NUM_CH-1:0]   emif_amm_ready;
    logic [NUM_CH-1:0]   mc_req_fire;
    logic [NUM_CH-1:0]   mc_rsp_fire;
    logic [NUM_CH-1:0]   eac2mc_ready;
    logic                csr_write_back;
    logic                csr_zero_out;
    logic                csr_clear_err;
    logic                mem_updater_start;
    updater_mode_t       mem_updater_mode;
    logic                mem_updater_done;
    logic                cafu_start;
    logic                cafu_done;
    buf_port_sel_t       buf_port_sel;
    arbiter_sel_t        arbiter_sel;
    logic                is_writing_back;
    logic                busy;
    logic                op_done;
    logic                drain_timeout_err;

    int errors = 0;
    int checks = 0;

    multi_chan_counter_ctrl #(
        .NUM_CH        (NUM_CH),
        .OUTST_W       (OUTST_W),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) u_dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .emif_amm_ready    (emif_amm_ready),
        .mc_req_fire       (mc_req_fire),
        .mc_rsp_fire       (mc_rsp_fire),
        .eac2mc_ready      (eac2mc_ready),
        .csr_write_back    (csr_write_back),
        .csr_zero_out      (csr_zero_out),
        .csr_clear_err     (csr_clear_err),
        .mem_updater_start (mem_updater_start),
        .mem_updater_mode  (mem_updater_mode),
        .mem_updater_done  (mem_updater_done),
        .cafu_start        (cafu_start),
        .cafu_done         (cafu_done),
        .buf_port_sel      (buf_port_sel),
        .arbiter_sel       (arbiter_sel),
        .is_writing_back   (is_writing_back),
        .busy              (busy),
        .op_done           (op_done),
        .drain_timeout_err (drain_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=hang expected=finish");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        reset_n          = 1'b0;
        emif_amm_ready   = 2'b11;
        mc_req_fire      = '0;
        mc_rsp_fire      = '0;
        csr_write_back   = 1'b0;
        csr_zero_out     = 1'b0;
        csr_clear_err    = 1'b0;
        mem_updater_done = 1'b0;
        cafu_done        = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_state", u_dut.r_state, IDLE_S);
        check("rst_ready", eac2mc_ready, 2'b00);
        check("rst_busy", busy, 1'b1);
        check("rst_cafu_start", cafu_start, 1'b0);
        check("rst_upd_start", mem_updater_start, 1'b0);
        check("rst_op_done", op_done, 1'b0);
        check("rst_err", drain_timeout_err, 1'b0);
        check("rst_is_wb", is_writing_back, 1'b0);
        check("rst_buf_sel", buf_port_sel, USER_B);
        check("rst_arb_sel", arbiter_sel, USER_A);
        check("rst_mode", mem_updater_mode, ZERO_OUT_COUNTER);

        // IDLE -> COUNTING after one cycle, ready follows EMIF per channel
        reset_n = 1'b1;
        tick();
        check("cnt_state", u_dut.r_state, COUNTING_S);
        check("cnt_busy", busy, 1'b0);
        check("cnt_ready", eac2mc_ready, 2'b11);
        emif_amm_ready = 2'b10;
        #1;
        check("cnt_ready_gate", eac2mc_ready, 2'b10);
        emif_amm_ready = 2'b11;

        // Saturation with 2-bit counters
        mc_req_fire = 2'b01;
        repeat (5) tick();
        mc_req_fire = 2'b00;
        check("sat_max", u_dut.g_ch[0].u_cnt.r_count, 2'd3);
        mc_rsp_fire = 2'b01;
        tick();
        check("sat_dec", u_dut.g_ch[0].u_cnt.r_count, 2'd2);
        mc_req_fire = 2'b01;
        tick();
        check("sat_both", u_dut.g_ch[0].u_cnt.r_count, 2'd2);
        mc_req_fire = 2'b00;
        mc_rsp_fire = 2'b10;
        tick();
        check("sat_underflow", u_dut.g_ch[1].u_cnt.r_count, 2'd0);
        mc_rsp_fire = 2'b01;
        tick();
        tick();
        mc_rsp_fire = 2'b00;
        check("sat_back_zero", u_dut.g_ch[0].u_cnt.r_count, 2'd0);

        // Write-back: 3 outstanding on ch0, 1 on ch1
        mc_req_fire = 2'b11;
        tick();
        mc_req_fire = 2'b01;
        tick();
        tick();
        mc_req_fire = 2'b00;
        check("wb_cnt0", u_dut.g_ch[0].u_cnt.r_count, 2'd3);
        check("wb_cnt1", u_dut.g_ch[1].u_cnt.r_count, 2'd1);
        csr_write_back = 1'b1;
        tick();
        csr_write_back = 1'b0;
        check("wb_drain", u_dut.r_state, DRAIN_S);
        check("wb_drain_ready", eac2mc_ready, 2'b00);
        check("wb_pend", u_dut.r_pend_wb, 1'b1);
        mc_rsp_fire = 2'b01;
        tick();
        check("wb_hold1", u_dut.r_state, DRAIN_S);
        tick();
        check("wb_hold2", u_dut.r_state, DRAIN_S);
        mc_rsp_fire = 2'b10;
        tick();
        check("wb_hold3", u_dut.r_state, DRAIN_S);
        mc_rsp_fire = 2'b01;
        tick();
        check("wb_hold4", u_dut.r_state, DRAIN_S);
        mc_rsp_fire = 2'b00;
        tick();
        check("wb_state", u_dut.r_state, WRITE_BACK_S);
        check("wb_cafu_start", cafu_start, 1'b1);
        check("wb_is_wb", is_writing_back, 1'b1);
        check("wb_buf_sel", buf_port_sel, CAFU_B);
        check("wb_mode", mem_updater_mode, WRITE_BACK_COUNTER);
        check("wb_pend_clr", u_dut.r_pend_wb, 1'b0);
        tick();
        check("wb_stay", u_dut.r_state, WRITE_BACK_S);
        check("wb_start_once", cafu_start, 1'b0);
        cafu_done = 1'b1;
        tick();
        cafu_done = 1'b0;
        check("wb_done_state", u_dut.r_state, COUNTING_S);
        check("wb_op_done", op_done, 1'b1);
        check("wb_ready_back", eac2mc_ready, 2'b11);
        tick();
        check("wb_op_done_pulse", op_done, 1'b0);

        // Chained write-back then zero-out, done honoured in entry cycle
        csr_write_back = 1'b1;
        csr_zero_out   = 1'b1;
        tick();
        csr_write_back = 1'b0;
        csr_zero_out   = 1'b0;
        check("ch_drain", u_dut.r_state, DRAIN_S);
        tick();
        check("ch_wb", u_dut.r_state, WRITE_BACK_S);
        check("ch_cafu_start", cafu_start, 1'b1);
        check("ch_wb_ready", eac2mc_ready, 2'b00);
        cafu_done = 1'b1;
        tick();
        cafu_done = 1'b0;
        check("ch_zo", u_dut.r_state, ZERO_OUT_S);
        check("ch_upd_start", mem_updater_start, 1'b1);
        check("ch_buf_sel", buf_port_sel, UPDATER_B);
        check("ch_mode", mem_updater_mode, ZERO_OUT_COUNTER);
        check("ch_zo_ready", eac2mc_ready, 2'b00);
        check("ch_no_op_done", op_done, 1'b0);
        csr_write_back = 1'b1;
        tick();
        csr_write_back = 1'b0;
        check("ch_zo_stay", u_dut.r_state, ZERO_OUT_S);
        check("ch_upd_once", mem_updater_start, 1'b0);
        check("ch_pend_wb", u_dut.r_pend_wb, 1'b1);
        mem_updater_done = 1'b1;
        tick();
        mem_updater_done = 1'b0;
        check("ch_back", u_dut.r_state, COUNTING_S);
        check("ch_op_done", op_done, 1'b1);
        tick();
        check("ch_redrain", u_dut.r_state, DRAIN_S);
        tick();
        check("ch_rewb", u_dut.r_state, WRITE_BACK_S);
        cafu_done = 1'b1;
        tick();
        cafu_done = 1'b0;
        check("ch_rewb_done", u_dut.r_state, COUNTING_S);

        // Drain timeout with one response never returned on ch1
        mc_req_fire = 2'b10;
        tick();
        mc_req_fire = 2'b00;
        csr_zero_out = 1'b1;
        tick();
        csr_zero_out = 1'b0;
        check("to_drain_entry", u_dut.r_state, DRAIN_S);
        for (int i = 0; i < DRAIN_TIMEOUT - 1; i++) begin
            tick();
            check("to_drain_hold", u_dut.r_state, DRAIN_S);
        end
        check("to_err_before", drain_timeout_err, 1'b0);
        tick();
        check("to_exit", u_dut.r_state, ZERO_OUT_S);
        check("to_err_set", drain_timeout_err, 1'b1);
        check("to_upd_start", mem_updater_start, 1'b1);
        mem_updater_done = 1'b1;
        tick();
        mem_updater_done = 1'b0;
        check("to_back", u_dut.r_state, COUNTING_S);
        check("to_cnt_kept", u_dut.g_ch[1].u_cnt.r_count, 2'd1);
        tick();
        tick();
        check("to_err_sticky", drain_timeout_err, 1'b1);
        csr_clear_err = 1'b1;
        tick();
        csr_clear_err = 1'b0;
        check("to_err_clear", drain_timeout_err, 1'b0);
        mc_rsp_fire = 2'b10;
        tick();
        mc_rsp_fire = 2'b00;

        // Reset during WRITE_BACK with zero-out pending
        csr_write_back = 1'b1;
        csr_zero_out   = 1'b1;
        tick();
        csr_write_back = 1'b0;
        csr_zero_out   = 1'b0;
        tick();
        check("rm_wb", u_dut.r_state, WRITE_BACK_S);
        check("rm_pend_zo", u_dut.r_pend_zo, 1'b1);
        reset_n = 1'b0;
        tick();
        check("rm_state", u_dut.r_state, IDLE_S);
        check("rm_ready", eac2mc_ready, 2'b00);
        check("rm_busy", busy, 1'b1);
        check("rm_is_wb", is_writing_back, 1'b0);
        check("rm_pend_lost", u_dut.r_pend_zo, 1'b0);
        check("rm_buf_sel", buf_port_sel, USER_B);
        reset_n = 1'b1;
        tick();
        check("rm_counting", u_dut.r_state, COUNTING_S);
        repeat (3) tick();
        check("rm_no_zo", u_dut.r_state, COUNTING_S);
        check("rm_no_upd", mem_updater_start, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
